// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad column scanner.
// Holds the scanner state encoding, column reset pattern and sign-key codes.
package keypad_pkg;

  localparam int COL_W  = 4;
  localparam int CODE_W = 4;
  localparam int SIGN_W = 3;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    SCAN         = 2'd0,
    PRESS_DB     = 2'd1,
    WAIT_RELEASE = 2'd2,
    RELEASE_DB   = 2'd3
  } scan_state_e;

  localparam logic [COL_W-1:0]  COL_RESET = 4'b0001;

  localparam logic [SIGN_W-1:0] SIGN_NONE = 3'b000;
  localparam logic [SIGN_W-1:0] SIGN_A    = 3'b001;
  localparam logic [SIGN_W-1:0] SIGN_HASH = 3'b010;
  localparam logic [SIGN_W-1:0] SIGN_BCD  = 3'b011;
  localparam logic [SIGN_W-1:0] SIGN_STAR = 3'b100;

  // One step of the one-hot column walk, MSB wraps back to bit 0.
  function automatic logic [COL_W-1:0] rotate_col(input logic [COL_W-1:0] col);
    return {col[COL_W-2:0], col[COL_W-1]};
  endfunction

endpackage

// File: rtl/keypad_col_scanner_if.sv
// Keypad-side bundle: row decoder inputs and debounced key outputs.
// master = scanner, slave = row decoder / consumer side.
interface keypad_col_scanner_if;
  import keypad_pkg::*;

  logic                key_pressed;
  logic [CODE_W-1:0]   key_value;
  logic [SIGN_W-1:0]   is_sign_key;
  logic [COL_W-1:0]    col_shift_reg;
  logic                key_valid;
  logic [CODE_W-1:0]   key_code;
  logic [SIGN_W-1:0]   key_sign;
  logic                key_held;

  modport master (
    input  key_pressed, key_value, is_sign_key,
    output col_shift_reg, key_valid, key_code, key_sign, key_held
  );

  modport slave (
    output key_pressed, key_value, is_sign_key,
    input  col_shift_reg, key_valid, key_code, key_sign, key_held
  );

endinterface

// File: rtl/keypad_col_scanner_debounce_counter.sv
// Saturating 8-bit stable-sample counter shared by press and release debounce.
// Terminal flag marks the count at which the next matching sample is accepted.
module debounce_counter
  import keypad_pkg::*;
#(
  parameter int TERMINAL = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_load_one,
  input  logic i_inc,
  output logic o_terminal
);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TERMINAL);
  localparam logic [CNT_W-1:0] CNT_MAX  = 8'hFF;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (i_clear) begin
      r_cnt <= 8'd0;
    end else if (i_load_one) begin
      r_cnt <= 8'd1;
    end else if (i_inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_terminal = (r_cnt == TERM_CNT);

endmodule

// File: rtl/keypad_col_scanner.sv
// Keypad column scanner: walks a one-hot column, debounces press and release,
// and emits a one-cycle key_valid pulse with the accepted key code and sign.
module keypad_col_scanner
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  slow_clk,
  input  logic                  rst,
  keypad_col_scanner_if.master  bus
);

  scan_state_e        r_state;
  logic [COL_W-1:0]   r_col;
  logic               r_key_valid;
  logic [CODE_W-1:0]  r_key_code;
  logic [SIGN_W-1:0]  r_key_sign;
  logic               r_key_held;
  logic [CODE_W-1:0]  r_cand_code;
  logic [SIGN_W-1:0]  r_cand_sign;

  logic w_match;
  logic w_term;
  logic w_cnt_clear;
  logic w_cnt_load_one;
  logic w_cnt_inc;

  assign w_match = bus.key_pressed &&
                   (bus.key_value == r_cand_code) &&
                   (bus.is_sign_key == r_cand_sign);

  debounce_counter #(
    .TERMINAL (DEBOUNCE_CYCLES - 1)
  ) u_debounce_counter (
    .clk        (slow_clk),
    .rst        (rst),
    .i_clear    (w_cnt_clear),
    .i_load_one (w_cnt_load_one),
    .i_inc      (w_cnt_inc),
    .o_terminal (w_term)
  );

  // Counter control mirrors the state transitions taken on the same edge.
  always_comb begin
    w_cnt_clear    = 1'b0;
    w_cnt_load_one = 1'b0;
    w_cnt_inc      = 1'b0;
    case (r_state)
      SCAN: begin
        if (bus.key_pressed) w_cnt_load_one = 1'b1;
        else                 w_cnt_clear    = 1'b1;
      end
      PRESS_DB: begin
        if (w_match && !w_term) w_cnt_inc   = 1'b1;
        else                    w_cnt_clear = 1'b1;
      end
      WAIT_RELEASE: begin
        if (!bus.key_pressed) w_cnt_load_one = 1'b1;
        else                  w_cnt_clear    = 1'b1;
      end
      RELEASE_DB: begin
        if (!bus.key_pressed && !w_term) w_cnt_inc   = 1'b1;
        else                             w_cnt_clear = 1'b1;
      end
      default: w_cnt_clear = 1'b1;
    endcase
  end

  always_ff @(posedge slow_clk) begin
    if (rst) begin
      r_state     <= SCAN;
      r_col       <= COL_RESET;
      r_key_valid <= 1'b0;
      r_key_code  <= 4'b0000;
      r_key_sign  <= SIGN_NONE;
      r_key_held  <= 1'b0;
      r_cand_code <= 4'b0000;
      r_cand_sign <= SIGN_NONE;
    end else begin
      r_key_valid <= 1'b0;
      case (r_state)
        SCAN: begin
          if (bus.key_pressed) begin
            r_cand_code <= bus.key_value;
            r_cand_sign <= bus.is_sign_key;
            r_state     <= PRESS_DB;
          end else begin
            r_col <= rotate_col(r_col);
          end
        end
        PRESS_DB: begin
          if (!w_match) begin
            r_state <= SCAN;
            r_col   <= rotate_col(r_col);
          end else if (w_term) begin
            r_key_valid <= 1'b1;
            r_key_code  <= r_cand_code;
            r_key_sign  <= r_cand_sign;
            r_key_held  <= 1'b1;
            r_state     <= WAIT_RELEASE;
          end else begin
            r_state <= PRESS_DB;
          end
        end
        WAIT_RELEASE: begin
          if (!bus.key_pressed) r_state <= RELEASE_DB;
          else                  r_state <= WAIT_RELEASE;
        end
        RELEASE_DB: begin
          // A bounce back to pressed restarts the release window.
          if (bus.key_pressed) begin
            r_state <= WAIT_RELEASE;
          end else if (w_term) begin
            r_state    <= SCAN;
            r_key_held <= 1'b0;
            r_col      <= rotate_col(r_col);
          end else begin
            r_state <= RELEASE_DB;
          end
        end
        default: begin
          r_state    <= SCAN;
          r_col      <= COL_RESET;
          r_key_held <= 1'b0;
        end
      endcase
    end
  end

  assign bus.col_shift_reg = r_col;
  assign bus.key_valid     = r_key_valid;
  assign bus.key_code      = r_key_code;
  assign bus.key_sign      = r_key_sign;
  assign bus.key_held      = r_key_held;

endmodule

// File: tb/tb_keypad_col_scanner.sv
// Directed bench for keypad_col_scanner with DEBOUNCE_CYCLES = 4.
// Outputs are sampled 1 time unit after each rising edge.
module tb_keypad_col_scanner;
  import keypad_pkg::*;

  logic slow_clk;
  logic rst;
  int   checks;
  int   errors;

  keypad_col_scanner_if bus ();

  keypad_col_scanner #(
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .slow_clk (slow_clk),
    .rst      (rst),
    .bus      (bus.master)
  );

  initial slow_clk = 1'b0;
  always #5 slow_clk = ~slow_clk;

  task automatic step();
    @(posedge slow_clk);
    #1;
  endtask

  task automatic drive(input logic kp, input logic [3:0] val, input logic [2:0] sgn);
    bus.key_pressed = kp;
    bus.key_value   = val;
    bus.is_sign_key = sgn;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] col, input logic vld,
                         input logic [3:0] code, input logic [2:0] sgn, input logic held);
    chk({tag, ".col"},   {4'h0, bus.col_shift_reg}, {4'h0, col});
    chk({tag, ".valid"}, {7'h0, bus.key_valid},     {7'h0, vld});
    chk({tag, ".code"},  {4'h0, bus.key_code},      {4'h0, code});
    chk({tag, ".sign"},  {5'h0, bus.key_sign},      {5'h0, sgn});
    chk({tag, ".held"},  {7'h0, bus.key_held},      {7'h0, held});
  endtask

  initial begin
    logic [3:0] ec;
    checks = 0;
    errors = 0;

    // Reset
    rst = 1'b1;
    drive(1'b0, 4'b0000, SIGN_NONE);
    step();
    step();
    chk_all("reset", 4'b0001, 1'b0, 4'b0000, 3'b000, 1'b0);
    rst = 1'b0;

    // Free-running scan, 8 edges
    ec = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      step();
      ec = {ec[2:0], ec[3]};
      chk("scan.col", {4'h0, bus.col_shift_reg}, {4'h0, ec});
      chk("scan.valid", {7'h0, bus.key_valid}, 8'h00);
    end
    step();
    chk("scan.to_col1", {4'h0, bus.col_shift_reg}, 8'h02);

    // Key "5" held 10 edges
    drive(1'b1, 4'b0101, SIGN_NONE);
    step(); chk_all("k5_e0", 4'b0010, 1'b0, 4'b0000, 3'b000, 1'b0);
    step(); chk_all("k5_e1", 4'b0010, 1'b0, 4'b0000, 3'b000, 1'b0);
    step(); chk_all("k5_e2", 4'b0010, 1'b0, 4'b0000, 3'b000, 1'b0);
    step(); chk_all("k5_e3", 4'b0010, 1'b1, 4'b0101, 3'b000, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(); chk_all("k5_hold", 4'b0010, 1'b0, 4'b0101, 3'b000, 1'b1);
    end
    drive(1'b0, 4'b0000, SIGN_NONE);
    for (int i = 0; i < 3; i++) begin
      step(); chk_all("k5_rel", 4'b0010, 1'b0, 4'b0101, 3'b000, 1'b1);
    end
    step(); chk_all("k5_scan", 4'b0100, 1'b0, 4'b0101, 3'b000, 1'b0);

    // "*" pressed 2 edges at column 0010 then released: aborted
    step(); step(); step();
    chk("star.col_before", {4'h0, bus.col_shift_reg}, 8'h02);
    drive(1'b1, 4'b0000, SIGN_STAR);
    step(); chk_all("star_e0", 4'b0010, 1'b0, 4'b0101, 3'b000, 1'b0);
    step(); chk_all("star_e1", 4'b0010, 1'b0, 4'b0101, 3'b000, 1'b0);
    drive(1'b0, 4'b0000, SIGN_NONE);
    step(); chk_all("star_abort", 4'b0100, 1'b0, 4'b0101, 3'b000, 1'b0);
    step(); chk("star.resume", {4'h0, bus.col_shift_reg}, 8'h08);

    // "A" accepted, release bounces 0,1,0,0,0,0
    drive(1'b1, 4'b1010, SIGN_A);
    for (int i = 0; i < 3; i++) begin
      step(); chk("A_db.valid", {7'h0, bus.key_valid}, 8'h00);
    end
    step(); chk_all("A_acc", 4'b1000, 1'b1, 4'b1010, 3'b001, 1'b1);
    drive(1'b0, 4'b0000, SIGN_NONE);
    step(); chk_all("A_r0", 4'b1000, 1'b0, 4'b1010, 3'b001, 1'b1);
    drive(1'b1, 4'b1010, SIGN_A);
    step(); chk_all("A_bounce", 4'b1000, 1'b0, 4'b1010, 3'b001, 1'b1);
    drive(1'b0, 4'b0000, SIGN_NONE);
    for (int i = 0; i < 3; i++) begin
      step(); chk_all("A_rdb", 4'b1000, 1'b0, 4'b1010, 3'b001, 1'b1);
    end
    step(); chk_all("A_scan", 4'b0001, 1'b0, 4'b1010, 3'b001, 1'b0);

    // Candidate changes mid-debounce: abort and advance
    drive(1'b1, 4'b0111, SIGN_NONE);
    step();
    drive(1'b1, 4'b0110, SIGN_NONE);
    step(); chk_all("mismatch", 4'b0010, 1'b0, 4'b1010, 3'b001, 1'b0);
    drive(1'b0, 4'b0000, SIGN_NONE);

    // Reset in PRESS_DB on cycle 2
    drive(1'b1, 4'b0011, SIGN_NONE);
    step();
    step();
    rst = 1'b1;
    step(); chk_all("rst_pdb", 4'b0001, 1'b0, 4'b0000, 3'b000, 1'b0);
    rst = 1'b0;

    // Reset on the edge that would raise key_valid
    step(); step(); step();
    rst = 1'b1;
    step(); chk_all("rst_pend", 4'b0001, 1'b0, 4'b0000, 3'b000, 1'b0);
    rst = 1'b0;
    drive(1'b0, 4'b0000, SIGN_NONE);
    step(); chk_all("rst_resume", 4'b0010, 1'b0, 4'b0000, 3'b000, 1'b0);

    // Keys "1" then "9"
    drive(1'b1, 4'b0001, SIGN_NONE);
    for (int i = 0; i < 3; i++) begin
      step(); chk("k1_db.valid", {7'h0, bus.key_valid}, 8'h00);
    end
    step(); chk_all("k1", 4'b0010, 1'b1, 4'b0001, 3'b000, 1'b1);
    drive(1'b0, 4'b0000, SIGN_NONE);
    step(); step(); step();
    step(); chk_all("k1_done", 4'b0100, 1'b0, 4'b0001, 3'b000, 1'b0);
    step(); chk_all("k1_between", 4'b1000, 1'b0, 4'b0001, 3'b000, 1'b0);
    drive(1'b1, 4'b1001, SIGN_NONE);
    for (int i = 0; i < 3; i++) begin
      step(); chk_all("k9_db", 4'b1000, 1'b0, 4'b0001, 3'b000, 1'b0);
    end
    step(); chk_all("k9", 4'b1000, 1'b1, 4'b1001, 3'b000, 1'b1);
    step(); chk_all("k9_hold", 4'b1000, 1'b0, 4'b1001, 3'b000, 1'b1);
    drive(1'b0, 4'b0000, SIGN_NONE);
    step(); step(); step();
    step(); chk_all("k9_done", 4'b0001, 1'b0, 4'b1001, 3'b000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
